// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: shares one combinational ALU between two requesters.
// Optional macro ALU_FIXED_PRI_EN selects strict req0 priority.
module alu_arbiter_seq #(
   parameter int WIDTH         = 16,
   parameter int MULDIV_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] alu_r0,
   input  logic             alu_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_out,
   output logic [WIDTH-1:0] rsp_r0,
   output logic             rsp_ovf,
   output logic             rsp_err
);

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_MUL = 4'h4;
   localparam logic [3:0] OP_DIV = 4'h8;
   localparam logic [3:0] OP_C   = 4'hC;
   localparam logic [3:0] OP_E   = 4'hE;
   localparam logic [3:0] OP_F   = 4'hF;

   localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t           r_state;
   logic             r_last_grant;
   logic             r_id;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_alu_in1;
   logic [WIDTH-1:0] r_alu_in2;
   logic [3:0]       r_alu_ctrl;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_out;
   logic [WIDTH-1:0] r_rsp_r0;
   logic             r_rsp_ovf;
   logic             r_rsp_err;

   logic             w_g0;
   logic             w_g1;
   logic             w_idle;
   logic             w_accept;
   logic [3:0]       w_sel_op;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic             w_legal;
   logic             w_muldiv;
   logic             w_divz;
   logic             w_bad;
   logic             w_cap_r0;
   logic             w_exec_last;

`ifdef ALU_FIXED_PRI_EN
   assign w_g0 = req0_valid;
`else
   // on a tie the requester that did not win last time is served
   assign w_g0 = req0_valid & (~req1_valid | r_last_grant);
`endif
   assign w_g1 = req1_valid & ~w_g0;

   // readys are forced low while reset is asserted
   assign w_idle     = (r_state == S_IDLE) & rst_n;
   assign req0_ready = w_idle & w_g0;
   assign req1_ready = w_idle & w_g1;
   assign w_accept   = req0_ready | req1_ready;

   assign w_sel_op = w_g1 ? req1_op : req0_op;
   assign w_sel_a  = w_g1 ? req1_a  : req0_a;
   assign w_sel_b  = w_g1 ? req1_b  : req0_b;

   // classify the selected op code
   always_comb begin
      w_legal  = 1'b0;
      w_muldiv = 1'b0;
      unique case (w_sel_op)
         OP_ADD, OP_SUB, OP_C, OP_E, OP_F: begin
            w_legal = 1'b1;
         end
         OP_MUL, OP_DIV: begin
            w_legal  = 1'b1;
            w_muldiv = 1'b1;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   assign w_divz = (w_sel_op == OP_DIV) & (w_sel_b == '0);
   assign w_bad  = ~w_legal | w_divz;

   assign w_cap_r0 = (r_alu_ctrl == OP_MUL) |
                     (r_alu_ctrl == OP_DIV);

   assign w_exec_last = (r_cnt == 4'd0);

   // control FSM with registered ALU operands and response fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_cnt        <= 4'd0;
         r_alu_in1    <= '0;
         r_alu_in2    <= '0;
         r_alu_ctrl   <= 4'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_out    <= '0;
         r_rsp_r0     <= '0;
         r_rsp_ovf    <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_id         <= w_g1;
                  r_last_grant <= w_g1;
                  if (w_bad) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_id    <= w_g1;
                     r_rsp_out   <= '0;
                     r_rsp_r0    <= '0;
                     r_rsp_ovf   <= 1'b0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     r_alu_in1  <= w_sel_a;
                     r_alu_in2  <= w_sel_b;
                     r_alu_ctrl <= w_sel_op;
                     r_cnt      <= w_muldiv ? MD_LOAD : 4'd0;
                     r_state    <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (w_exec_last) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_id;
                  r_rsp_out   <= alu_out;
                  r_rsp_r0    <= w_cap_r0 ? alu_r0 : '0;
                  r_rsp_ovf   <= alu_ovf;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_alu_ctrl  <= 4'd0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_in1   = r_alu_in1;
   assign alu_in2   = r_alu_in2;
   assign alu_ctrl  = r_alu_ctrl;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_out   = r_rsp_out;
   assign rsp_r0    = r_rsp_r0;
   assign rsp_ovf   = r_rsp_ovf;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// tb_alu_arbiter_seq: directed scenarios plus a randomized run
// against a transaction-level reference of the arbiter.
`timescale 1ns/1ps
module tb_alu_arbiter_seq;

   localparam int W  = 16;
   localparam int MC = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready;
   logic [3:0]   req0_op;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready;
   logic [3:0]   req1_op;
   logic [W-1:0] req1_a, req1_b;
   logic [W-1:0] alu_in1, alu_in2;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_out, alu_r0;
   logic         alu_ovf;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_out, rsp_r0;
   logic         rsp_ovf, rsp_err;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   alu_arbiter_seq #(.WIDTH(W), .MULDIV_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_r0(alu_r0), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_r0(rsp_r0), .rsp_ovf(rsp_ovf),
      .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural ALU: returns {ovf, r0, out}; r0/ovf are junk for
   // ops whose r0 must be suppressed by the arbiter
   function automatic logic [2*W:0] alu_f(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W-1:0]   o;
      logic [W-1:0]   r;
      logic           v;
      logic [2*W-1:0] p;
      o = '0;
      r = a ^ 16'h5A5A;
      v = a[3] ^ b[5];
      p = '0;
      case (op)
         4'h1: begin
            o = a + b;
            v = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]);
         end
         4'h2: begin
            o = a - b;
            v = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]);
         end
         4'h4: begin
            p = {16'h0, a} * {16'h0, b};
            o = p[W-1:0];
            r = p[2*W-1:W];
            v = |p[2*W-1:W];
         end
         4'h8: begin
            if (b != 0) begin
               o = a / b;
               r = a % b;
            end
            v = 1'b0;
         end
         4'hC: o = a & b;
         4'hE: o = a | b;
         4'hF: o = a ^ b;
         default: o = 16'hDEAD;
      endcase
      return {v, r, o};
   endfunction

   always_comb {alu_ovf, alu_r0, alu_out} = alu_f(alu_ctrl, alu_in1, alu_in2);

   // expected response {err, ovf, r0, out} from the op rules
   function automatic logic [2*W+1:0] ref_rsp(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [2*W:0] t;
      logic         legal;
      legal = (op == 4'h1) || (op == 4'h2) || (op == 4'h4) ||
              (op == 4'h8) || (op == 4'hC) || (op == 4'hE) ||
              (op == 4'hF);
      if (!legal || (op == 4'h8 && b == 0))
         return {1'b1, 1'b0, 16'h0, 16'h0};
      t = alu_f(op, a, b);
      if (op == 4'h4 || op == 4'h8)
         return {1'b0, t[2*W], t[2*W-1:W], t[W-1:0]};
      return {1'b0, t[2*W], 16'h0, t[W-1:0]};
   endfunction

   function automatic int ref_lat(input logic [3:0] op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      logic [2*W+1:0] e;
      e = ref_rsp(op, a, b);
      if (e[2*W+1]) return 1;
      if (op == 4'h4 || op == 4'h8) return 1 + MC;
      return 2;
   endfunction

   task automatic idle_inputs();
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp_ready  = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      req0_valid = 1; req0_op = 4'h1;
      req1_valid = 1; req1_op = 4'h2;
      rsp_ready  = 1;
      #1;
      n_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 00",
                  {req0_ready, req1_ready});
      end
      n_run++;
      if ({alu_in1, alu_in2, alu_ctrl} !== '0) begin
         n_fail++;
         $display("FAIL reset_alu: got in1=%h in2=%h ctrl=%h expected 0",
                  alu_in1, alu_in2, alu_ctrl);
      end
      n_run++;
      if ({rsp_valid, rsp_id, rsp_out, rsp_r0, rsp_ovf, rsp_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: got v=%b id=%b out=%h r0=%h ovf=%b err=%b expected 0",
                  rsp_valid, rsp_id, rsp_out, rsp_r0, rsp_ovf, rsp_err);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_single_add();
      int n0;
      do_reset();
      rsp_ready = 1;
      req0_valid = 1; req0_op = 4'h1; req0_a = 5; req0_b = 7;
      #1;
      n_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL add_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      n0 = cyc;
      @(negedge clk);
      req0_valid = 0;
      #1;
      n_run++;
      if (alu_ctrl !== 4'h1 || alu_in1 !== 5 || alu_in2 !== 7 || rsp_valid !== 0) begin
         n_fail++;
         $display("FAIL add_exec: got ctrl=%h in1=%0d in2=%0d v=%b expected 1/5/7/0",
                  alu_ctrl, alu_in1, alu_in2, rsp_valid);
      end
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 1 || cyc - n0 != 2 || rsp_out !== 12 || rsp_id !== 0 ||
          rsp_err !== 0 || rsp_ovf !== 0 || rsp_r0 !== 0) begin
         n_fail++;
         $display("FAIL add_rsp: got v=%b lat=%0d out=%0d id=%b err=%b ovf=%b r0=%h expected 1/2/12/0/0/0/0",
                  rsp_valid, cyc - n0, rsp_out, rsp_id, rsp_err, rsp_ovf, rsp_r0);
      end
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 0 || alu_ctrl !== 0) begin
         n_fail++;
         $display("FAIL add_retire: got v=%b ctrl=%h expected 0/0", rsp_valid, alu_ctrl);
      end
   endtask

   task automatic test_contention();
      int got;
      int budget;
      int exp_id;
      int rsps;
      bit q[$];
      do_reset();
      rsp_ready = 1;
      req0_valid = 1; req0_op = 4'h2; req0_a = 10; req0_b = 3;
      req1_valid = 1; req1_op = 4'h2; req1_a = 10; req1_b = 3;
      got = 0; budget = 0; rsps = 0;
      while (got < 4 && budget < 60) begin
         #1;
         if (rsp_valid) begin
            n_run++;
            if (q.size() == 0 || rsp_out !== 7 || rsp_id !== q[0] || rsp_err !== 0) begin
               n_fail++;
               $display("FAIL cont_rsp: got out=%0d id=%b err=%b expected 7/%0d/0",
                        rsp_out, rsp_id, rsp_err, (q.size() != 0) ? int'(q[0]) : -1);
            end
            if (q.size() != 0) void'(q.pop_front());
            rsps++;
         end
         if (req0_ready || req1_ready) begin
`ifdef ALU_FIXED_PRI_EN
            exp_id = 0;
`else
            exp_id = got % 2;
`endif
            n_run++;
            if (req0_ready !== (exp_id == 0) || req1_ready !== (exp_id == 1)) begin
               n_fail++;
               $display("FAIL cont_grant%0d: got %b%b expected id %0d",
                        got, req0_ready, req1_ready, exp_id);
            end
            q.push_back(exp_id[0]);
            got++;
         end
         @(negedge clk);
         budget++;
      end
      n_run++;
      if (got != 4 || rsps < 3) begin
         n_fail++;
         $display("FAIL cont_timeout: got %0d grants %0d rsps expected 4/3+", got, rsps);
      end
      req0_valid = 0; req1_valid = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_mul();
      int n0;
      do_reset();
      rsp_ready = 0;
      req1_valid = 1; req1_op = 4'h4; req1_a = 300; req1_b = 300;
      #1;
      n_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL mul_grant: got %b expected 01", {req0_ready, req1_ready});
      end
      n0 = cyc;
      @(negedge clk);
      req1_valid = 0;
      for (int k = 1; k <= MC; k++) begin
         #1;
         n_run++;
         if (alu_ctrl !== 4'h4 || alu_in1 !== 300 || alu_in2 !== 300 || rsp_valid !== 0) begin
            n_fail++;
            $display("FAIL mul_hold%0d: got ctrl=%h in1=%0d in2=%0d v=%b expected 4/300/300/0",
                     k, alu_ctrl, alu_in1, alu_in2, rsp_valid);
         end
         @(negedge clk);
      end
      #1;
      n_run++;
      if (rsp_valid !== 1 || cyc - n0 != 1 + MC || {rsp_r0, rsp_out} !== 32'd90000 ||
          rsp_id !== 1 || rsp_err !== 0) begin
         n_fail++;
         $display("FAIL mul_rsp: got v=%b lat=%0d r0=%h out=%h id=%b err=%b expected 1/%0d/0001/5f90/1/0",
                  rsp_valid, cyc - n0, rsp_r0, rsp_out, rsp_id, rsp_err, 1 + MC);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_div_err();
      do_reset();
      rsp_ready = 0;
      req0_valid = 1; req0_op = 4'h8; req0_a = 9; req0_b = 0;
      #1;
      @(negedge clk);
      req0_valid = 0;
      #1;
      n_run++;
      if (rsp_valid !== 1 || rsp_err !== 1 || rsp_out !== 0 || rsp_r0 !== 0 ||
          rsp_ovf !== 0 || rsp_id !== 0 || alu_ctrl !== 0) begin
         n_fail++;
         $display("FAIL divz_rsp: got v=%b err=%b out=%h r0=%h ovf=%b id=%b ctrl=%h expected 1/1/0/0/0/0/0",
                  rsp_valid, rsp_err, rsp_out, rsp_r0, rsp_ovf, rsp_id, alu_ctrl);
      end
      rsp_ready = 1;
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 0 || alu_ctrl !== 0) begin
         n_fail++;
         $display("FAIL divz_retire: got v=%b ctrl=%h expected 0/0", rsp_valid, alu_ctrl);
      end
      req1_valid = 1; req1_op = 4'h3; req1_a = 5; req1_b = 5;
      #1;
      @(negedge clk);
      req1_valid = 0;
      #1;
      n_run++;
      if (rsp_valid !== 1 || rsp_err !== 1 || rsp_out !== 0 || rsp_id !== 1 || alu_ctrl !== 0) begin
         n_fail++;
         $display("FAIL illegal_rsp: got v=%b err=%b out=%h id=%b ctrl=%h expected 1/1/0/1/0",
                  rsp_valid, rsp_err, rsp_out, rsp_id, alu_ctrl);
      end
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 0;
      req0_valid = 1; req0_op = 4'hE; req0_a = 16'h00F0; req0_b = 16'h0F00;
      #1;
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_op = 4'h1; req1_a = 3; req1_b = 4;
      #1;
      n_run++;
      if (req1_ready !== 0) begin
         n_fail++;
         $display("FAIL bp_exec_ready: got %b expected 0", req1_ready);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_run++;
         if (rsp_valid !== 1 || rsp_out !== 16'h0FF0 || rsp_id !== 0 || rsp_err !== 0 ||
             {req0_ready, req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b out=%h id=%b err=%b rdy=%b%b expected 1/0ff0/0/0/00",
                     i, rsp_valid, rsp_out, rsp_id, rsp_err, req0_ready, req1_ready);
         end
         @(negedge clk);
      end
      rsp_ready = 1;
      #1;
      n_run++;
      if (rsp_valid !== 1 || req1_ready !== 0) begin
         n_fail++;
         $display("FAIL bp_hs: got v=%b rdy1=%b expected 1/0", rsp_valid, req1_ready);
      end
      @(negedge clk);
      rsp_ready = 0;
      #1;
      n_run++;
      if (rsp_valid !== 0 || req1_ready !== 1) begin
         n_fail++;
         $display("FAIL bp_release: got v=%b rdy1=%b expected 0/1", rsp_valid, req1_ready);
      end
      @(negedge clk);
      req1_valid = 0;
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 1 || rsp_out !== 7 || rsp_id !== 1) begin
         n_fail++;
         $display("FAIL bp_next: got v=%b out=%0d id=%b expected 1/7/1",
                  rsp_valid, rsp_out, rsp_id);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic test_reset_midop();
      do_reset();
      rsp_ready = 1;
      req0_valid = 1; req0_op = 4'h8; req0_a = 100; req0_b = 7;
      #1;
      @(negedge clk);
      req0_valid = 0;
      #2;
      rst_n = 0;
      #1;
      n_run++;
      if ({alu_in1, alu_in2, alu_ctrl, rsp_valid, rsp_out, rsp_r0, rsp_err,
           req0_ready, req1_ready} !== '0) begin
         n_fail++;
         $display("FAIL midrst_async: got ctrl=%h in1=%h v=%b out=%h expected all 0",
                  alu_ctrl, alu_in1, rsp_valid, rsp_out);
      end
      @(negedge clk);
      rst_n = 1;
      req0_valid = 1; req0_op = 4'h1; req0_a = 1; req0_b = 1;
      req1_valid = 1; req1_op = 4'h1; req1_a = 2; req1_b = 2;
      #1;
      n_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL midrst_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      n_run++;
      if (rsp_valid !== 0) begin
         n_fail++;
         $display("FAIL midrst_stale: got v=%b expected 0", rsp_valid);
      end
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 1 || rsp_out !== 2 || rsp_id !== 0 || rsp_err !== 0) begin
         n_fail++;
         $display("FAIL midrst_rsp: got v=%b out=%0d id=%b err=%b expected 1/2/0/0",
                  rsp_valid, rsp_out, rsp_id, rsp_err);
      end
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 0) begin
         n_fail++;
         $display("FAIL midrst_extra: got v=%b expected 0", rsp_valid);
      end
      rsp_ready = 0;
   endtask

   function automatic logic [3:0] rand_op();
      logic [3:0] ops [7];
      int r;
      ops = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF};
      r = $urandom_range(0, 9);
      if (r < 7) return ops[r];
      if (r == 7) return 4'h8;
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic logic [W-1:0] rand_b();
      if ($urandom_range(0, 5) == 0) return '0;
      return W'($urandom);
   endfunction

   task automatic test_random();
      bit             busy;
      bit             last;
      bit             e_id;
      bit             g0, g1;
      bit             drop0, drop1;
      logic [2*W+1:0] e_rsp;
      int             due;
      int             nacc;
      do_reset();
      busy = 0; last = 1; due = 0; nacc = 0;
      drop0 = 0; drop1 = 0;
      e_id = 0; e_rsp = '0;
      for (int c = 0; c < 3000; c++) begin
         if (drop0) req0_valid = 0;
         if (drop1) req1_valid = 0;
         drop0 = 0; drop1 = 0;
         if (!req0_valid && $urandom_range(0, 2) != 0) begin
            req0_valid = 1; req0_op = rand_op();
            req0_a = W'($urandom); req0_b = rand_b();
         end
         if (!req1_valid && $urandom_range(0, 2) != 0) begin
            req1_valid = 1; req1_op = rand_op();
            req1_a = W'($urandom); req1_b = rand_b();
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (!busy) begin
`ifdef ALU_FIXED_PRI_EN
            g0 = req0_valid;
`else
            g0 = req0_valid && (!req1_valid || last);
`endif
            g1 = req1_valid && !g0;
            n_run++;
            if (req0_ready !== g0 || req1_ready !== g1 || rsp_valid !== 0) begin
               n_fail++;
               $display("FAIL rand_grant@%0d: got rdy=%b%b v=%b expected %b%b/0",
                        cyc, req0_ready, req1_ready, rsp_valid, g0, g1);
            end
            if (g0 || g1) begin
               e_id = g1;
               last = g1;
               if (g1) begin
                  e_rsp = ref_rsp(req1_op, req1_a, req1_b);
                  due   = cyc + ref_lat(req1_op, req1_a, req1_b);
                  drop1 = 1;
               end else begin
                  e_rsp = ref_rsp(req0_op, req0_a, req0_b);
                  due   = cyc + ref_lat(req0_op, req0_a, req0_b);
                  drop0 = 1;
               end
               busy = 1;
               nacc++;
            end
         end else begin
            n_run++;
            if ({req0_ready, req1_ready} !== 2'b00 || rsp_valid !== (cyc >= due)) begin
               n_fail++;
               $display("FAIL rand_busy@%0d: got rdy=%b%b v=%b expected 00/%b",
                        cyc, req0_ready, req1_ready, rsp_valid, cyc >= due);
            end
            if (cyc >= due) begin
               n_run++;
               if ({rsp_err, rsp_ovf, rsp_r0, rsp_out} !== e_rsp || rsp_id !== e_id) begin
                  n_fail++;
                  $display("FAIL rand_rsp@%0d: got id=%b err=%b ovf=%b r0=%h out=%h expected id=%b {err,ovf,r0,out}=%h",
                           cyc, rsp_id, rsp_err, rsp_ovf, rsp_r0, rsp_out, e_id, e_rsp);
               end
               if (rsp_ready) busy = 0;
            end
         end
         @(negedge clk);
      end
      n_run++;
      if (nacc < 300) begin
         n_fail++;
         $display("FAIL rand_progress: got %0d accepts expected at least 300", nacc);
      end
      idle_inputs();
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      idle_inputs();
      test_reset();
      test_single_add();
      test_contention();
      test_mul();
      test_div_err();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
- Shares the single combinational 16-bit ALU between two requesters: req0 is the execute stage, req1 is the address/branch-calculation path.
- Arbitrates with round-robin, registers the operands and ctrl code, and holds them for the op latency.
- Captures out/r0/overflow and returns them on a response channel with valid/ready backpressure.
- Sits between the decode/execute logic and the ALU. Filters illegal ops and divide-by-zero, so those never reach the ALU.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- MULDIV_CYCLES, 3, cycles the EXEC state holds for ctrl 4'h4 (mul) and 4'h8 (div); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_op  in  4  ALU ctrl code.
- req0_a  in  WIDTH  operand in1.
- req0_b  in  WIDTH  operand in2.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as req0, for requester 1.
- alu_in1  out  WIDTH  registered operand to the ALU.
- alu_in2  out  WIDTH  registered operand to the ALU.
- alu_ctrl  out  4  registered ctrl code to the ALU.
- alu_out  in  WIDTH  ALU result.
- alu_r0  in  WIDTH  ALU high product / remainder.
- alu_ovf  in  1  ALU overflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_out  out  WIDTH  result.
- rsp_r0  out  WIDTH  r0 value; 0 for ops other than 4 and 8.
- rsp_ovf  out  1  overflow.
- rsp_err  out  1  illegal op or divide by zero.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; last_grant = 1, so req0 wins the first tie.
  - All outputs are 0: readys, alu_in1, alu_in2, alu_ctrl, and all rsp_* signals.
- Legal ops: 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF. Every other code is illegal.
- IDLE:
  - reqN_ready is combinational and asserts only in IDLE, for the granted requester only. At most one ready is high per cycle.
  - Grant rule: if exactly one valid, grant it. If both are valid, grant the one that is not last_grant.
  - On handshake, latch op/a/b and id, and update last_grant.
  - Illegal op, or op 4'h8 with b==0: go to RESP with rsp_err=1 and rsp_out=rsp_r0=rsp_ovf=0. The ALU is not driven (alu_ctrl stays 0).
  - Otherwise drive alu_in1, alu_in2 and alu_ctrl from the registers and go to EXEC.
- EXEC:
  - Latency is 1 cycle for ops 1, 2, C, E, F, and MULDIV_CYCLES cycles for ops 4 and 8, counted by a 4-bit down-counter.
  - alu_in1, alu_in2 and alu_ctrl stay stable for the whole of EXEC.
  - In the last EXEC cycle, capture alu_out, alu_ovf, and alu_r0 (alu_r0 only for ops 4/8, otherwise 0). Go to RESP with rsp_err=0.
- RESP:
  - rsp_valid=1; the rsp_* fields hold stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE and clear alu_ctrl to 0.
  - No new request is accepted in RESP.
  - Best-case throughput is one op per 3 cycles (IDLE, EXEC, RESP).
- End-to-end latency: the accept edge at cycle N gives rsp_valid at N+2 for single-cycle ops, N+1+MULDIV_CYCLES for mul/div, and N+1 for errors.
- Requesters must hold valid and fields stable until ready. A requester that drops valid before grant is simply not granted.
- Reset mid-operation aborts immediately: the op is lost, no response is produced, and there is no partial capture.
- Overflow semantics are those of the ALU and are passed through unchanged.

Optional Feature:
- ALU_FIXED_PRI_EN:
  - Defined: strict priority, req0 always wins when both are valid. last_grant is still updated but ignored.
  - Undefined: round-robin as described above.

Test Plan:
- Single add: req0 op=1, a=5, b=7 at cycle 0 -> alu_ctrl=1 in cycle 1; rsp_valid at cycle 2 with rsp_out=12, rsp_id=0, err=0, ovf=0.
- Contention: req0 and req1 valid together every op, each op=2 with a=10, b=3, rsp_ready=1 -> grants alternate 0,1,0,1 and every rsp_out=7. With ALU_FIXED_PRI_EN defined, all grants go to 0 until req0 drops valid.
- Multiply latency: MULDIV_CYCLES=3, req1 op=4, a=300, b=300 -> alu_ctrl=4 held for 3 cycles; rsp at accept+4 with {rsp_r0,rsp_out}=90000 (r0=16'h0001, out=16'h5F90).
- Divide errors: op=8, a=9, b=0 -> rsp_err=1, all data 0, rsp at accept+1, alu_ctrl never leaves 0. op=4'h3 -> rsp_err=1.
- Backpressure: rsp_ready held 0 for 5 cycles after a rsp_valid for op=E, a=16'h00F0, b=16'h0F00 -> rsp fields stable at 16'h0FF0, both readys 0, and a pending req1 is not accepted until the cycle after the rsp handshake.
- Reset mid-op: assert rst_n=0 during EXEC of a div -> all outputs 0 asynchronously. After release, a req0 op=1, a=1, b=1 completes with rsp_out=2 and no stale response.
